ternary_mux41: RTL and testbench

- 4-to-1 selector: one of four equal-width data lanes is routed to the output under a 2-bit select.
- Provides two outputs:
  - a combinational output, zero latency, used by glue logic;
  - a registered copy with a valid flag, for timing-critical consumers.
- Leaf datapath block, instantiated wherever a small lane select is needed.

---
 rtl/mux_pkg.sv | 17 +
 rtl/ternary_mux21.sv | 19 +
 rtl/ternary_mux41.sv | 82 ++++++++
 tb/tb_ternary_mux41.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the ternary 4:1 lane selector.
//   NUM_LANES : number of data lanes routed by the selector
//   SEL_W     : width of the lane select
//   sel_t     : lane select type, with named lane constants SEL_L0..SEL_L3
package mux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_L0 = 2'd0;
  localparam sel_t SEL_L1 = 2'd1;
  localparam sel_t SEL_L2 = 2'd2;
  localparam sel_t SEL_L3 = 2'd3;

endpackage

// File: rtl/ternary_mux21.sv
// 2:1 conditional-select cell: y = s ? b : a.
// Ports:
//   a, b : WIDTH-bit data inputs (a chosen when s=0, b when s=1)
//   s    : select
//   y    : WIDTH-bit selected data
// An X/Z select propagates X through the conditional operator rather than
// defaulting to either input.
module ternary_mux21 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/ternary_mux41.sv
// 4:1 lane selector with a zero-latency combinational output and a
// registered copy carrying a one-cycle valid pulse per accepted input.
// Ports:
//   clk       : system clock, registered path samples on the rising edge
//   rst_n     : asynchronous active-low reset (clears y_q and out_valid)
//   a         : four packed WIDTH-bit lanes, lane0 in the low bits
//   s         : lane select, s[1] is the MSB
//   in_valid  : qualifies a/s for capture into the registered path
//   y         : combinational selected lane
//   y_q       : registered selected lane, held when in_valid=0
//   out_valid : high for one cycle after each accepted input
module ternary_mux41
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES*WIDTH-1:0] a,
  input  sel_t                       s,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           y_q,
  output logic                       out_valid
);

  logic [WIDTH-1:0] lane [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane[i] = a[i*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;

  // s[0] picks within each pair, s[1] then picks the pair.
  ternary_mux21 #(.WIDTH(WIDTH)) u_mux_lo (
    .a (lane[0]),
    .b (lane[1]),
    .s (s[0]),
    .y (lo_pair)
  );

  ternary_mux21 #(.WIDTH(WIDTH)) u_mux_hi (
    .a (lane[2]),
    .b (lane[3]),
    .s (s[0]),
    .y (hi_pair)
  );

  ternary_mux21 #(.WIDTH(WIDTH)) u_mux_out (
    .a (lo_pair),
    .b (hi_pair),
    .s (s[1]),
    .y (y)
  );

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      data_d = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign y_q       = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ternary_mux41.sv
// Self-checking bench for ternary_mux41: a WIDTH=1 instance for the
// exhaustive truth table and a WIDTH=8 instance for lanes, latency,
// reset and streaming, checked against a behavioural model.
`timescale 1ns/1ps
module tb_ternary_mux41;
  import mux_pkg::*;

  logic       clk;
  logic       rst_n;

  logic [3:0]  a1;
  sel_t        s1;
  logic        in_valid1;
  logic [0:0]  y1;
  logic [0:0]  y_q1;
  logic        out_valid1;

  logic [31:0] a8;
  sel_t        s8;
  logic        in_valid8;
  logic [7:0]  y8;
  logic [7:0]  y_q8;
  logic        out_valid8;

  int total = 0;
  int bad   = 0;

  logic [7:0] lanes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  ternary_mux41 #(.WIDTH(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .a (a1), .s (s1), .in_valid (in_valid1),
    .y (y1), .y_q (y_q1), .out_valid (out_valid1)
  );

  ternary_mux41 #(.WIDTH(8)) dut8 (
    .clk (clk), .rst_n (rst_n), .a (a8), .s (s8), .in_valid (in_valid8),
    .y (y8), .y_q (y_q8), .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the registered path for the WIDTH=8 instance.
  logic [7:0] m_yq;
  logic       m_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq = 8'h00;
      m_v  = 1'b0;
    end else begin
      m_v = in_valid8;
      if (in_valid8) m_yq = a8[8*int'(s8) +: 8];
    end
  end

  always @(negedge clk) begin
    chk("model_y8",   {56'd0, y8},   {56'd0, a8[8*int'(s8) +: 8]});
    chk("model_yq8",  {56'd0, y_q8}, {56'd0, m_yq});
    chk("model_ov8",  {63'd0, out_valid8}, {63'd0, m_v});
    chk("model_ov1",  {63'd0, out_valid1}, 64'd0);
  end

  task automatic after_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] v;
    rst_n     = 1'b0;
    a1        = '0;
    s1        = SEL_L0;
    in_valid1 = 1'b0;
    a8        = {lanes[3], lanes[2], lanes[1], lanes[0]};
    s8        = SEL_L0;
    in_valid8 = 1'b0;

    #1;
    chk("rst_yq", {56'd0, y_q8}, 64'd0);
    chk("rst_ov", {63'd0, out_valid8}, 64'd0);

    // Exhaustive WIDTH=1 truth table.
    for (int n = 0; n < 64; n++) begin
      v = n[5:0];
      {s1, a1} = v;
      #1;
      chk("tt1", {63'd0, y1}, {63'd0, v[int'(v[5:4])]});
    end
    {s1, a1} = 6'b011011; #1; chk("tt1_lit_011011", {63'd0, y1}, 64'd1);
    {s1, a1} = 6'b100100; #1; chk("tt1_lit_100100", {63'd0, y1}, 64'd1);
    {s1, a1} = 6'b110111; #1; chk("tt1_lit_110111", {63'd0, y1}, 64'd0);

    // Combinational path is independent of reset.
    s8 = SEL_L3;
    #1;
    chk("y_in_reset", {56'd0, y8}, 64'hD4);

    after_neg();
    rst_n = 1'b1;

    // Wide lanes, stepping the select.
    for (int i = 0; i < 4; i++) begin
      after_neg();
      s8 = sel_t'(i);
      #1;
      chk("wide_lane", {56'd0, y8}, {56'd0, lanes[i]});
    end
    chk("wide_lit_d4", {56'd0, y8}, 64'hD4);

    // Registered latency.
    after_neg();
    s8 = SEL_L2; in_valid8 = 1'b1;
    after_pos();
    chk("lat_yq", {56'd0, y_q8}, 64'hC3);
    chk("lat_ov", {63'd0, out_valid8}, 64'd1);
    after_neg();
    in_valid8 = 1'b0;
    after_pos();
    chk("hold_yq", {56'd0, y_q8}, 64'hC3);
    chk("hold_ov", {63'd0, out_valid8}, 64'd0);

    // Asynchronous reset mid-stream.
    after_neg();
    s8 = SEL_L3; in_valid8 = 1'b1;
    after_pos();
    chk("pre_rst_yq", {56'd0, y_q8}, 64'hD4);
    chk("pre_rst_ov", {63'd0, out_valid8}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_yq", {56'd0, y_q8}, 64'd0);
    chk("async_rst_ov", {63'd0, out_valid8}, 64'd0);
    after_pos();
    chk("in_rst_yq", {56'd0, y_q8}, 64'd0);
    chk("in_rst_ov", {63'd0, out_valid8}, 64'd0);
    after_neg();
    rst_n = 1'b1;
    #1;
    chk("release_ov", {63'd0, out_valid8}, 64'd0);
    after_pos();
    chk("first_cap_yq", {56'd0, y_q8}, 64'hD4);
    chk("first_cap_ov", {63'd0, out_valid8}, 64'd1);
    after_neg();
    in_valid8 = 1'b0;
    after_pos();

    // Streaming, back-to-back valids.
    for (int i = 0; i < 4; i++) begin
      after_neg();
      s8 = sel_t'(i); in_valid8 = 1'b1;
      after_pos();
      chk("stream_yq", {56'd0, y_q8}, {56'd0, lanes[i]});
      chk("stream_ov", {63'd0, out_valid8}, 64'd1);
    end
    after_neg();
    in_valid8 = 1'b0;
    after_pos();
    chk("stream_end_ov", {63'd0, out_valid8}, 64'd0);
    chk("stream_end_yq", {56'd0, y_q8}, 64'hD4);

    after_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
